// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter that lets two read requesters share one
//               memory port, with at most one transaction outstanding.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_pick;
    logic   w_gnt;
    logic   w_rvalid;

    // On a tie the requester not served last wins; otherwise the sole requester.
    assign w_pick = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        mem_req_o   = 1'b0;
        w_gnt       = 1'b0;
        w_rvalid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req_i | m1_req_i) begin
                    w_state_nxt = ST_REQ;
                    w_owner_nxt = w_pick;
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                w_gnt     = mem_gnt_i;
                if (mem_gnt_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rvalid = mem_rvalid_i;
                if (mem_rvalid_i) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_addr_o  = r_owner ? m1_addr_i : m0_addr_i;

    assign m0_gnt_o    = w_gnt & ~r_owner;
    assign m1_gnt_o    = w_gnt &  r_owner;
    assign m0_rvalid_o = w_rvalid & ~r_owner;
    assign m1_rvalid_o = w_rvalid &  r_owner;

    // Data is broadcast; consumers qualify it with their own rvalid.
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a delayed memory model.
// Revision    : 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int GNT_DLY = 2;
    localparam int RV_DLY  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic          m0_gnt_o, m0_rvalid_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic          m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m1_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          owner_o;

    logic          auto_mem   = 1'b1;
    logic          man_gnt    = 1'b0;
    logic          man_rvalid = 1'b0;
    logic [DW-1:0] man_rdata  = '0;
    logic          model_gnt, model_rvalid;
    logic [DW-1:0] model_rdata;

    assign mem_gnt_i    = auto_mem ? model_gnt    : man_gnt;
    assign mem_rvalid_i = auto_mem ? model_rvalid : man_rvalid;
    assign mem_rdata_i  = auto_mem ? model_rdata  : man_rdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    // Memory: grant GNT_DLY cycles into a request, data RV_DLY cycles after the handshake.
    logic [DW-1:0] mem [0:63];
    int            g_cnt, r_cnt;
    logic          pending;
    logic [AW-1:0] p_addr;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_gnt <= 1'b0; model_rvalid <= 1'b0; model_rdata <= '0;
            g_cnt <= 0; r_cnt <= 0; pending <= 1'b0; p_addr <= '0;
        end else begin
            model_gnt    <= 1'b0;
            model_rvalid <= 1'b0;
            if (pending) begin
                if (r_cnt == RV_DLY - 1) begin
                    model_rvalid <= 1'b1;
                    model_rdata  <= mem[p_addr[7:2]];
                    pending      <= 1'b0;
                    r_cnt        <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end else if (mem_req_o && model_gnt) begin
                pending <= 1'b1; r_cnt <= 0; g_cnt <= 0; p_addr <= mem_addr_o;
            end else if (mem_req_o) begin
                if (g_cnt == GNT_DLY - 1) begin
                    model_gnt <= 1'b1; g_cnt <= 0;
                end else begin
                    g_cnt <= g_cnt + 1;
                end
            end
        end
    end

    // Observation log: monitor only appends, tests only read.
    int            n_gnt0 = 0, n_gnt1 = 0, n_rv0 = 0, n_rv1 = 0;
    int            gnt_q[$];
    logic [DW:0]   obs_q[$];
    logic [DW:0]   exp_q[$];
    int            obs_rd = 0;
    int            errors = 0, checks = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_gnt_o)    begin n_gnt0++; gnt_q.push_back(0); end
            if (m1_gnt_o)    begin n_gnt1++; gnt_q.push_back(1); end
            if (m0_rvalid_o) begin n_rv0++; obs_q.push_back({1'b0, m0_rdata_o}); end
            if (m1_rvalid_o) begin n_rv1++; obs_q.push_back({1'b1, m1_rdata_o}); end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; auto_mem = 1'b0; man_gnt = 1'b1; man_rvalid = 1'b1;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o});
        end
        checks++;
        if (owner_o !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b expected 0", owner_o); end
        m0_req_i = 1'b0; m1_req_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
        tick();
        rst_n = 1'b1; auto_mem = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int  g0, g1, v0, v1;
        bit  seen, ok;
        logic [DW:0] e, o;
        g0 = n_gnt0; g1 = n_gnt1; v0 = n_rv0; v1 = n_rv1;
        exp_q.push_back({1'b0, 32'h0090_0093});
        m0_addr_i = 8'h04; m0_req_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (m0_gnt_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL single_gnt: got none expected m0 grant"); end
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 8'h04}) begin
            errors++; $display("FAIL single_addr: got req=%b addr=%h expected req=1 addr=04", mem_req_o, mem_addr_o);
        end
        m0_req_i = 1'b0;
        wait_obs(obs_rd + 1, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_rvalid: got none expected m0 rvalid"); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_data: got %h expected %h", o, e); end
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL single_idle: got mem_req=%b expected 0", mem_req_o); end
        checks++;
        if ({n_gnt0 - g0, n_gnt1 - g1, n_rv0 - v0, n_rv1 - v1} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL single_counts: got g0=%0d g1=%0d v0=%0d v1=%0d expected 1 0 1 0",
                     n_gnt0 - g0, n_gnt1 - g1, n_rv0 - v0, n_rv1 - v1);
        end
    endtask

    task automatic test_round_robin();
        int  base, ng;
        bit  ok;
        logic [DW:0] e, o;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        base = gnt_q.size(); ng = 0;
        m0_addr_i = 8'h08; m1_addr_i = 8'h0C;
        for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? {1'b0, mem[2]} : {1'b1, mem[3]});
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        for (int i = 0; i < 120 && ng < 4; i++) begin
            tick();
            if (gnt_q.size() > base + ng) begin
                checks++;
                if (gnt_q[base + ng] !== ng % 2 || owner_o !== ng[0]) begin
                    errors++;
                    $display("FAIL rr_order%0d: got gnt=%0d owner=%b expected %0d", ng, gnt_q[base + ng], owner_o, ng % 2);
                end
                checks++;
                if (mem_addr_o !== (ng[0] ? 8'h0C : 8'h08)) begin
                    errors++; $display("FAIL rr_addr%0d: got %h expected %h", ng, mem_addr_o, ng[0] ? 8'h0C : 8'h08);
                end
                ng++;
            end
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        checks++;
        if (ng != 4) begin errors++; $display("FAIL rr_grants: got %0d expected 4", ng); end
        wait_obs(obs_rd + exp_q.size(), 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_rvalid: got %0d responses expected more", obs_q.size() - obs_rd); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin errors++; $display("FAIL rr_data: got %h expected %h", o, e); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int  g0, g1;
        bit  ok;
        logic [DW:0] e, o;
        g0 = n_gnt0; g1 = n_gnt1;
        m1_addr_i = 8'h10; m1_req_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back({1'b1, mem[4]});
            wait_obs(obs_rd + 1, 40, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_rvalid%0d: got none expected m1 rvalid", t); end
            e = exp_q.pop_front();
            if (ok) begin
                o = obs_q[obs_rd]; obs_rd++;
                checks++;
                if (o !== e) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", t, o, e); end
            end
            if (t == 2) m1_req_i = 1'b0;
            tick();
            checks++;
            if (mem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got mem_req=%b expected 0", t, mem_req_o); end
            if (t < 2) begin
                tick();
                checks++;
                if (mem_req_o !== 1'b1) begin errors++; $display("FAIL b2b_next%0d: got mem_req=%b expected 1", t, mem_req_o); end
            end
        end
        checks++;
        if (n_gnt0 - g0 != 0 || n_gnt1 - g1 != 3) begin
            errors++; $display("FAIL b2b_owner: got g0=%0d g1=%0d expected 0 3", n_gnt0 - g0, n_gnt1 - g1);
        end
    endtask

    task automatic test_stray_rvalid();
        auto_mem = 1'b0; man_rvalid = 1'b1; man_gnt = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== 5'b0) begin
            errors++;
            $display("FAIL stray_idle: got %b expected 00000",
                     {mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o});
        end
        man_gnt = 1'b0; m0_addr_i = 8'h30; m0_req_i = 1'b1;
        tick(); tick();
        checks++;
        if ({mem_req_o, m0_rvalid_o, m1_rvalid_o} !== 3'b100) begin
            errors++; $display("FAIL stray_req: got %b expected 100", {mem_req_o, m0_rvalid_o, m1_rvalid_o});
        end
        man_rvalid = 1'b0; man_gnt = 1'b1;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin errors++; $display("FAIL manual_gnt: got %b expected 10", {m0_gnt_o, m1_gnt_o}); end
        m0_req_i = 1'b0;
        tick();
        checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin errors++; $display("FAIL gnt_in_resp: got %b expected 00", {m0_gnt_o, m1_gnt_o}); end
        man_gnt = 1'b0; man_rvalid = 1'b1;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== {2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL manual_rvalid: got %b %h %h expected 10 deadbeef deadbeef",
                               {m0_rvalid_o, m1_rvalid_o}, m0_rdata_o, m1_rdata_o);
        end
        tick();
        checks++;
        if ({mem_req_o, m0_rvalid_o, m1_rvalid_o} !== 3'b000) begin
            errors++; $display("FAIL stray_after: got %b expected 000", {mem_req_o, m0_rvalid_o, m1_rvalid_o});
        end
        man_rvalid = 1'b0; auto_mem = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        int  v0, v1, base;
        bit  seen, ok;
        logic [DW:0] e, o;
        exp_q.push_back({1'b0, mem[5]});
        m0_addr_i = 8'h14; m0_req_i = 1'b1;
        wait_obs(obs_rd + 1, 40, ok);
        m0_req_i = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_pre: got none expected m0 rvalid"); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_pre_data: got %h expected %h", o, e); end
        end
        tick();
        m1_addr_i = 8'h18; m1_req_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin tick(); if (m1_gnt_o) seen = 1'b1; end
        m1_req_i = 1'b0;
        tick();
        v0 = n_rv0; v1 = n_rv1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, m1_gnt_o, m1_rvalid_o, owner_o} !== 4'b0) begin
            errors++; $display("FAIL mid_reset: got %b expected 0000", {mem_req_o, m1_gnt_o, m1_rvalid_o, owner_o});
        end
        tick(); tick();
        rst_n = 1'b1; auto_mem = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0BAD_0BAD;
        tick(); tick();
        man_rvalid = 1'b0; auto_mem = 1'b1;
        checks++;
        if (n_rv0 - v0 != 0 || n_rv1 - v1 != 0) begin
            errors++; $display("FAIL mid_stale: got v0=%0d v1=%0d expected 0 0", n_rv0 - v0, n_rv1 - v1);
        end
        base = gnt_q.size();
        exp_q.push_back({1'b0, mem[7]});
        m0_addr_i = 8'h1C; m1_addr_i = 8'h20; m0_req_i = 1'b1; m1_req_i = 1'b1;
        for (int i = 0; i < 30 && gnt_q.size() == base; i++) tick();
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        checks++;
        if (gnt_q.size() == base || gnt_q[base] !== 0 || owner_o !== 1'b0) begin
            errors++; $display("FAIL mid_tie: got owner=%b grants=%0d expected m0 first", owner_o, gnt_q.size() - base);
        end
        wait_obs(obs_rd + 1, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_tie_rvalid: got none expected m0 rvalid"); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_tie_data: got %h expected %h", o, e); end
        end
        tick();
    endtask

    task automatic test_drop_req();
        bit  seen, ok;
        logic [DW:0] e, o;
        exp_q.push_back({1'b0, mem[9]});
        m0_addr_i = 8'h24; m0_req_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin tick(); if (mem_req_o) seen = 1'b1; end
        checks++;
        if (!seen || m0_gnt_o !== 1'b0) begin
            errors++; $display("FAIL drop_req: got mem_req=%b gnt=%b expected 1 0", mem_req_o, m0_gnt_o);
        end
        m0_req_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin tick(); if (m0_gnt_o) seen = 1'b1; end
        checks++;
        if (!seen) begin errors++; $display("FAIL drop_gnt: got none expected m0 grant"); end
        wait_obs(obs_rd + 1, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_rvalid: got none expected m0 rvalid"); end
        while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin errors++; $display("FAIL drop_data: got %h expected %h", o, e); end
        end
        tick(); tick();
        checks++;
        if ({mem_req_o, owner_o} !== 2'b00) begin
            errors++; $display("FAIL drop_idle: got req=%b owner=%b expected 0 0", mem_req_o, owner_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        mem[1] = 32'h0090_0093;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_stray_rvalid();
        test_reset_mid();
        test_drop_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the byte-address width of every port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the read-data width of every port.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port m0_req_i, input, 1 bit: requester 0 (instruction fetch) request.
REQ-006 Port m0_addr_i, input, ADDR_WIDTH bits: requester 0 address.
REQ-007 Port m0_gnt_o, output, 1 bit: requester 0 grant.
REQ-008 Port m0_rvalid_o, output, 1 bit: requester 0 read data valid.
REQ-009 Port m0_rdata_o, output, DATA_WIDTH bits: requester 0 read data.
REQ-010 Ports m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o and m1_rdata_o SHALL be identical in direction and width to the m0 ports, for requester 1 (debug/trace).
REQ-011 Port mem_req_o, output, 1 bit: request to the shared memory.
REQ-012 Port mem_addr_o, output, ADDR_WIDTH bits: address to the shared memory.
REQ-013 Port mem_gnt_i, input, 1 bit: memory grant.
REQ-014 Port mem_rvalid_i, input, 1 bit: memory read data valid.
REQ-015 Port mem_rdata_i, input, DATA_WIDTH bits: memory read data.
REQ-016 Port owner_o, output, 1 bit: index of the requester that currently owns the memory, or that owned it last.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, REQ and RESP, and SHALL allow at most one outstanding memory transaction.
REQ-018 In IDLE with any mX_req_i high, the block SHALL latch an owner and enter REQ on the next edge; with no request it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: a sole requester wins; when both request, the requester that was not last served wins.
REQ-020 The last-served register SHALL reset to 1, so requester 0 wins the first tie.
REQ-021 In REQ, mem_req_o SHALL be 1 and mem_addr_o SHALL combinationally equal the owner's mX_addr_i.
REQ-022 In IDLE and RESP, mem_req_o SHALL be 0.
REQ-023 Owner grant: in REQ, mX_gnt_o SHALL equal mem_gnt_i, combinationally in the same cycle; otherwise it SHALL be 0.
REQ-024 The non-owner's gnt_o SHALL always be 0.
REQ-025 On mem_gnt_i=1 in REQ, the FSM SHALL enter RESP.
REQ-026 In RESP, the owner's mX_rvalid_o SHALL equal mem_rvalid_i combinationally; the non-owner's rvalid SHALL be 0.
REQ-027 On mem_rvalid_i=1 in RESP, the FSM SHALL return to IDLE and update last-served to the owner.
REQ-028 After each response, IDLE SHALL last at least one cycle; back-to-back transactions therefore cost response cycle + 1 idle cycle before the next mem_req_o.
REQ-029 mem_rvalid_i SHALL be ignored in IDLE and REQ: no mX_rvalid_o is produced, and it covers stale responses after reset.
REQ-030 mem_gnt_i SHALL be ignored outside REQ.
REQ-031 m0_rdata_o and m1_rdata_o SHALL both be driven by mem_rdata_i unconditionally; consumers qualify the data with rvalid.
REQ-032 Requesters hold req and addr until their grant; the owner is locked from IDLE->REQ until response, and a requester dropping req while in REQ SHALL NOT abort the transaction.
REQ-033 owner_o SHALL reflect the latched owner register.

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE, the owner register SHALL be 0 and the last-served register SHALL be 1.
REQ-035 While rst_n=0, mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o and m1_rvalid_o SHALL all be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no grant or rvalid emitted for it.

Verification
REQ-037 A single m0 read of addr 0x04 against a memory with 2-cycle grant and 2-cycle rvalid delay (mem[1]=0x00900093) SHALL produce exactly one m0_gnt_o pulse, then m0_rvalid_o=1 with m0_rdata_o=0x00900093, and m1 outputs SHALL stay 0.
REQ-038 With m0 and m1 requesting simultaneously from reset, the grant order SHALL be m0, m1, m0, m1 over four transactions, with owner_o toggling accordingly.
REQ-039 With m1 alone requesting continuously, every grant SHALL go to m1, and consecutive mem_req_o assertions SHALL be separated by at least one idle cycle.
REQ-040 mem_rvalid_i pulsed in IDLE SHALL produce m0_rvalid_o=0 and m1_rvalid_o=0.
REQ-041 rst_n pulled low while in RESP, followed by mem_rvalid_i=1 after release, SHALL produce no mX_rvalid_o, and the next tie SHALL be won by m0.
REQ-042 m0 dropping req_i while in REQ SHALL still result in the owner receiving the grant and rvalid, with the FSM returning to IDLE.
